master_cmd_order_tracker: RTL

Per-master read-order tracker for the router. It tags every accepted read command with {master id, target slave, per-slave sequence number} and queues the tag in issue order. It presents the oldest tag to the response path so returning slave data can be matched to the expected sequence. It generalises the fixed 4-slave/3-bit tracker: slave count, sequence width and depth are parameters, it uses proper valid/ready and pop handshakes, and it adds per-slave pending flags and overflow detection.

---
 rtl/master_cmd_order_tracker.sv | 114 +++++++++++
 1 files changed

// File: rtl/master_cmd_order_tracker.sv
// rtl/master_cmd_order_tracker.sv - per-master read-order tag queue with per-slave sequence numbering
module master_cmd_order_tracker #(
    parameter int ADDR_WIDTH  = 32,
    parameter int MASTER_N    = 0,
    parameter int MASTER_ID_W = 2,
    parameter int SLAVE_N     = 4,
    parameter int SEQ_W       = 3,
    parameter int DEPTH_EXP   = 3,
    localparam int SW         = $clog2(SLAVE_N),
    localparam int TAG_W      = MASTER_ID_W + SW + SEQ_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    input  logic                  cmd_ready,
    input  logic                  cmd_rd,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic                  tag_valid,
    output logic [TAG_W-1:0]      tag,
    input  logic                  tag_pop,
    output logic                  track_full,
    output logic [SLAVE_N-1:0]    slave_pending,
    output logic                  ovf_err
);

    localparam int DEPTH = 1 << DEPTH_EXP;
    localparam logic [MASTER_ID_W-1:0] MID = MASTER_ID_W'(MASTER_N);
    localparam logic [DEPTH_EXP:0] FULL_CNT = {1'b1, {DEPTH_EXP{1'b0}}};

    logic [TAG_W-1:0]     mem [DEPTH];
    logic [DEPTH_EXP-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [DEPTH_EXP:0]   fill, fill_nxt;
    logic [SEQ_W-1:0]     seq_cnt [SLAVE_N];
    logic [DEPTH_EXP:0]   pend_cnt [SLAVE_N];
    logic [DEPTH_EXP:0]   pend_nxt [SLAVE_N];
    logic [SW-1:0]        push_slave, head_slave;
    logic                 push_req, push_acc, pop, ovf_drop;
    logic [TAG_W-1:0]     new_tag, head_nxt;
    logic                 unused_addr;

    assign unused_addr = ^cmd_addr[ADDR_WIDTH-SW-1:0];
    assign push_slave  = cmd_addr[ADDR_WIDTH-1 -: SW];
    assign head_slave  = tag[SEQ_W +: SW];
    assign pop         = tag_valid && tag_pop;
    assign push_req    = cmd_valid && cmd_ready && cmd_rd;
    // A simultaneous pop frees the slot, so a full queue still accepts the push.
    assign push_acc    = push_req && (!track_full || pop);
    assign ovf_drop    = push_req && !push_acc;
    assign new_tag     = {MID, push_slave, seq_cnt[push_slave]};
    assign rd_nxt      = rd_ptr + DEPTH_EXP'(pop);

    always_comb begin
        fill_nxt = fill;
        if (push_acc && !pop)
            fill_nxt = fill + (DEPTH_EXP+1)'(1);
        else if (pop && !push_acc)
            fill_nxt = fill - (DEPTH_EXP+1)'(1);
    end

    // Bypass the new entry when it lands in the slot that becomes the head.
    always_comb begin
        head_nxt = mem[rd_nxt];
        if (push_acc && rd_nxt == wr_ptr)
            head_nxt = new_tag;
    end

    always_comb begin
        for (int s = 0; s < SLAVE_N; s++) begin
            pend_nxt[s] = pend_cnt[s];
            if (push_acc && push_slave == SW'(s) && !(pop && head_slave == SW'(s)))
                pend_nxt[s] = pend_cnt[s] + (DEPTH_EXP+1)'(1);
            else if (pop && head_slave == SW'(s) && !(push_acc && push_slave == SW'(s)))
                pend_nxt[s] = pend_cnt[s] - (DEPTH_EXP+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fill          <= '0;
            tag_valid     <= 1'b0;
            tag           <= '0;
            track_full    <= 1'b0;
            slave_pending <= '0;
            ovf_err       <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            for (int s = 0; s < SLAVE_N; s++) begin
                seq_cnt[s]  <= '0;
                pend_cnt[s] <= '0;
            end
        end else begin
            if (push_acc) begin
                mem[wr_ptr]         <= new_tag;
                wr_ptr              <= wr_ptr + DEPTH_EXP'(1);
                seq_cnt[push_slave] <= seq_cnt[push_slave] + SEQ_W'(1);
            end
            rd_ptr     <= rd_nxt;
            fill       <= fill_nxt;
            tag_valid  <= (fill_nxt != '0);
            if (fill_nxt != '0)
                tag <= head_nxt;
            track_full <= (fill_nxt == FULL_CNT);
            for (int s = 0; s < SLAVE_N; s++) begin
                pend_cnt[s]      <= pend_nxt[s];
                slave_pending[s] <= (pend_nxt[s] != '0);
            end
            if (ovf_drop)
                ovf_err <= 1'b1;
        end
    end

endmodule
